// File: rtl/bcd_cntr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_cntr_ctrl
//  Description : Sequencer for a multi-digit packed-BCD event counter.
//                Accepts start/stop/clear commands, counts rising edges of
//                evt_i while running, and halts with done_o when the count
//                reaches the target latched at start.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        system clock, rising edge
//    rst        synchronous active-high reset
//    start_i    start from IDLE (latches target_i) or resume from PAUSE
//    stop_i     pause a run (RUN -> PAUSE)
//    clear_i    zero the count and return to IDLE from any state
//    evt_i      event level input; one count per 0->1 transition
//    target_i   packed BCD terminal value, digit 0 in [3:0]
//    count_o    packed BCD count (registered)
//    busy_o     high while running
//    done_o     high while halted on a target match
//    wrap_o     one-cycle pulse on all-9s -> all-0s rollover
//    cfg_err_o  one-cycle pulse when a start is rejected for a bad target
// ============================================================================
module bcd_cntr_ctrl #(
    parameter int DIGITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                stop_i,
    input  logic                clear_i,
    input  logic                evt_i,
    input  logic [4*DIGITS-1:0] target_i,
    output logic [4*DIGITS-1:0] count_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                wrap_o,
    output logic                cfg_err_o
);

    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t         state_q;
    logic [W-1:0]   count_q;
    logic [W-1:0]   target_q;
    logic           evt_q;
    logic           busy_q;
    logic           done_q;
    logic           wrap_q;
    logic           cfg_err_q;

    // Incremented count and the ripple carry feeding each digit.
    logic [W-1:0]   count_d;
    logic [DIGITS:0] w_carry;
    logic [DIGITS-1:0] w_dig_bad;
    logic           w_edge;
    logic           w_hit;

    assign w_edge     = evt_i & ~evt_q;
    assign w_carry[0] = 1'b1;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_dig
            assign count_d[4*g +: 4] = !w_carry[g]             ? count_q[4*g +: 4] :
                                       (count_q[4*g +: 4] == 4'd9) ? 4'd0 :
                                       count_q[4*g +: 4] + 4'd1;
            assign w_carry[g+1] = w_carry[g] & (count_q[4*g +: 4] == 4'd9);
            assign w_dig_bad[g] = (target_i[4*g +: 4] > 4'd9);
        end
    endgenerate

    // An all-zero latched target selects free-run: no match is ever taken.
    assign w_hit = (count_d == target_q) && (target_q != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            target_q  <= '0;
            evt_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wrap_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            evt_q     <= evt_i;
            wrap_q    <= 1'b0;
            cfg_err_q <= 1'b0;

            if (clear_i) begin
                // Target is intentionally kept across a clear.
                state_q <= ST_IDLE;
                count_q <= '0;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        // stop outranks start, so a simultaneous stop masks it.
                        if (!stop_i && start_i) begin
                            if (|w_dig_bad) begin
                                cfg_err_q <= 1'b1;
                            end else begin
                                target_q <= target_i;
                                state_q  <= ST_RUN;
                                busy_q   <= 1'b1;
                            end
                        end
                    end
                    ST_RUN: begin
                        if (stop_i) begin
                            state_q <= ST_PAUSE;
                            busy_q  <= 1'b0;
                        end else if (w_edge) begin
                            count_q <= count_d;
                            wrap_q  <= w_carry[DIGITS];
                            if (w_hit) begin
                                state_q <= ST_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end
                    end
                    ST_PAUSE: begin
                        if (!stop_i && start_i) begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                    default: begin
                        // DONE: held until clear.
                    end
                endcase
            end
        end
    end

    assign count_o   = count_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign wrap_o    = wrap_q;
    assign cfg_err_o = cfg_err_q;

endmodule
`default_nettype wire
